// File: rtl/serial_add_pkg.sv
// serial_add_pkg: state encoding and default operand width for the serial adder
package serial_add_pkg;
  localparam int WIDTH_DEF = 8;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/fa_cell.sv
// fa_cell: 1-bit full adder from two half-adder stages and an OR on the carries
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic s1, c1, c2;
  assign s1 = a ^ b;
  assign c1 = a & b;
  assign s  = s1 ^ ci;
  assign c2 = s1 & ci;
  assign co = c1 | c2;
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder sequencing one shared full-adder cell LSB first
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH + 1);
  state_t state, state_nx;
  logic [WIDTH-1:0] a_sr, b_sr, res;
  logic [CW-1:0] cnt;
  logic carry, fa_s, fa_co, last;
  fa_cell u_fa (.a(a_sr[0]), .b(b_sr[0]), .ci(carry), .s(fa_s), .co(fa_co));
  assign last      = cnt == CW'(WIDTH - 1);
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign busy      = state != IDLE;
  assign sum       = res;
  assign cout      = carry;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // next state: accept in IDLE, WIDTH edges of ADD, hold DONE until taken
  always_comb
    state_nx = state == IDLE ? (in_valid ? ADD : IDLE) :
               state == ADD  ? (last ? DONE : ADD) :
               state == DONE ? (out_ready ? IDLE : DONE) : IDLE;
  // datapath: load operands on accept, then shift one bit through the cell per edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_sr  <= '0;
      b_sr  <= '0;
      res   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      a_sr  <= a;
      b_sr  <= b;
      carry <= cin;
      cnt   <= '0;
    end else if (state == ADD) begin
      a_sr  <= a_sr >> 1;
      b_sr  <= b_sr >> 1;
      res   <= (res >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
      carry <= fa_co;
      cnt   <= cnt + 1'b1;
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed and random checks of the serial adder against plain arithmetic
module tb_serial_add_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic cin = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic in_ready, out_valid, cout, busy;
  logic [7:0] sum;
  int vectors = 0;
  int miscompares = 0;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one transaction: accept, count edges to out_valid, hold DONE, then hand off
  task automatic xact(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                      input int hold, input bit rnd, input bit toggle);
    logic [8:0] exp;
    logic [7:0] s0;
    logic c0, r;
    int n;
    exp = 9'(ta) + 9'(tb_) + 9'(tc);
    chk("idle_in_ready", in_ready, 1);
    a = ta; b = tb_; cin = tc; in_valid = 1'b1;
    step();
    n = 1;
    if (!toggle) in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
    while (!out_valid && n < 40) begin
      chk("add_in_ready", in_ready, 0);
      chk("add_busy", busy, 1);
      if (toggle) begin a = ~a; b = b + 8'd1; end
      out_ready = 1'($urandom);
      step();
      n++;
    end
    in_valid = 1'b0;
    chk("latency_edges", n, 9);
    chk("sum", sum, exp[7:0]);
    chk("cout", cout, exp[8]);
    s0 = sum; c0 = cout;
    for (int k = 0; k < 50; k++) begin
      r = k < hold ? 1'b0 : (rnd && k < 20) ? 1'($urandom) : 1'b1;
      out_ready = r;
      step();
      if (r) begin
        chk("post_valid", out_valid, 0);
        chk("post_in_ready", in_ready, 1);
        chk("post_busy", busy, 0);
        break;
      end
      chk("hold_valid", out_valid, 1);
      chk("hold_sum", sum, s0);
      chk("hold_cout", cout, c0);
    end
    out_ready = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    step();
    rst_n = 1'b1;
    step();
    xact(8'h05, 8'h03, 1'b0, 0, 1'b0, 1'b0);
    xact(8'hFF, 8'h01, 1'b0, 0, 1'b0, 1'b0);
    xact(8'hFF, 8'hFF, 1'b1, 0, 1'b0, 1'b0);
    xact(8'h00, 8'h00, 1'b0, 0, 1'b0, 1'b0);
    xact(8'hA5, 8'h5A, 1'b1, 3, 1'b0, 1'b0);
    xact(8'h3C, 8'hC4, 1'b0, 0, 1'b0, 1'b1);
    a = 8'h77; b = 8'h99; cin = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    chk("mid_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_in_ready", in_ready, 1);
    chk("arst_busy", busy, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_sum", sum, 0);
    step();
    rst_n = 1'b1;
    chk("rel_out_valid", out_valid, 0);
    xact(8'h10, 8'h20, 1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 1000; i++)
      xact(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 2)), 1'b1, 1'($urandom));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
